// File: rtl/fft_peak_picker.sv
// fft_peak_picker: streaming top-N local-maximum picker over one FFT magnitude frame,
// result table sorted by descending magnitude and released under valid/ready.
module fft_peak_picker #(
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 10,
  parameter int FRAME_LEN = 1024,
  parameter int NUM_PEAKS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             s_mag_tdata,
  input  logic                          s_mag_tvalid,
  input  logic                          s_mag_tlast,
  output logic                          s_mag_tready,
  input  logic [IDX_W-1:0]              cfg_bin_lo,
  input  logic [IDX_W-1:0]              cfg_bin_hi,
  input  logic [DATA_W-1:0]             cfg_threshold,
  output logic                          m_peak_valid,
  input  logic                          m_peak_ready,
  output logic [NUM_PEAKS*DATA_W-1:0]   m_peak_val,
  output logic [NUM_PEAKS*IDX_W-1:0]    m_peak_idx,
  output logic [3:0]                    m_peak_count,
  output logic                          m_frame_err
);
  typedef enum logic [1:0] {COLLECT, FLUSH, RESULT} state_t;
  state_t r_state, w_next_state;
  logic [IDX_W-1:0]  r_k, r_cur_idx, r_lo, r_hi;
  logic [DATA_W-1:0] r_prev, r_cur, r_thr;
  logic [DATA_W-1:0] r_val [NUM_PEAKS];
  logic [IDX_W-1:0]  r_idx [NUM_PEAKS];
  logic [DATA_W-1:0] w_ins_val [NUM_PEAKS];
  logic [IDX_W-1:0]  w_ins_idx [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] w_gt;
  logic [3:0] r_cnt;
  logic r_err;
  logic w_acc, w_k_end, w_last, w_eval, w_hit, w_take;
  logic [DATA_W-1:0] w_nbr;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= COLLECT;
    else r_state <= w_next_state;
  always_comb begin
    s_mag_tready = r_state == COLLECT;
    m_peak_valid = r_state == RESULT;
    w_next_state = (r_state == COLLECT && w_last) ? FLUSH :
                   (r_state == FLUSH)             ? RESULT :
                   (r_state == RESULT && m_peak_ready) ? COLLECT : r_state;
  end
  assign w_acc   = s_mag_tvalid & s_mag_tready;
  assign w_k_end = r_k == IDX_W'(FRAME_LEN - 1);
  assign w_last  = w_acc & (s_mag_tlast | w_k_end);
  assign w_take  = m_peak_valid & m_peak_ready;
  // bin k is judged when bin k+1 arrives; the frame's last bin is judged in FLUSH against a zero neighbour
  assign w_eval  = (w_acc && r_k != '0) || r_state == FLUSH;
  assign w_nbr   = (r_state == FLUSH) ? '0 : s_mag_tdata;
  assign w_hit   = w_eval && r_cur > r_prev && r_cur >= w_nbr && r_cur >= r_thr &&
                   r_cur_idx >= r_lo && r_cur_idx <= r_hi;
  // strict compare keeps earlier bins above later equal ones
  always_comb begin
    for (int i = 0; i < NUM_PEAKS; i++) w_gt[i] = r_cur > r_val[i];
    w_ins_val[0] = w_gt[0] ? r_cur : r_val[0];
    w_ins_idx[0] = w_gt[0] ? r_cur_idx : r_idx[0];
    for (int i = 1; i < NUM_PEAKS; i++) begin
      w_ins_val[i] = w_gt[i-1] ? r_val[i-1] : w_gt[i] ? r_cur : r_val[i];
      w_ins_idx[i] = w_gt[i-1] ? r_idx[i-1] : w_gt[i] ? r_cur_idx : r_idx[i];
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_k <= '0;
      r_cur_idx <= '0;
      r_prev <= '0;
      r_cur <= '0;
      r_lo <= '0;
      r_hi <= '0;
      r_thr <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < NUM_PEAKS; i++) begin
        r_val[i] <= '0;
        r_idx[i] <= '0;
      end
    end else begin
      if (w_acc) begin
        r_prev <= (r_k == '0) ? '0 : r_cur;
        r_cur <= s_mag_tdata;
        r_cur_idx <= r_k;
        r_k <= w_last ? '0 : r_k + IDX_W'(1);
      end
      if (w_acc && r_k == '0) begin
        r_lo <= cfg_bin_lo;
        r_hi <= cfg_bin_hi;
        r_thr <= cfg_threshold;
      end
      if (w_last) r_err <= s_mag_tlast != w_k_end;
      if (w_hit) begin
        r_val <= w_ins_val;
        r_idx <= w_ins_idx;
        r_cnt <= r_cnt + {3'b000, r_cnt != 4'(NUM_PEAKS)};
      end
      if (w_take) begin
        r_cnt <= '0;
        r_err <= 1'b0;
        for (int i = 0; i < NUM_PEAKS; i++) begin
          r_val[i] <= '0;
          r_idx[i] <= '0;
        end
      end
    end
  end
  for (genvar i = 0; i < NUM_PEAKS; i++) begin : g_out
    assign m_peak_val[i*DATA_W +: DATA_W] = r_val[i];
    assign m_peak_idx[i*IDX_W +: IDX_W]   = r_idx[i];
  end
  assign m_peak_count = r_cnt;
  assign m_frame_err  = r_err;
endmodule

// File: tb/tb_fft_peak_picker.sv
// tb_fft_peak_picker: directed frames with hand-computed peak tables for fft_peak_picker.
module tb_fft_peak_picker;
  localparam int DW = 32;
  localparam int IW = 10;
  localparam int NP = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [DW-1:0] s_mag_tdata = '0;
  logic s_mag_tvalid = 1'b0;
  logic s_mag_tlast = 1'b0;
  logic s_mag_tready;
  logic [IW-1:0] cfg_bin_lo = '0;
  logic [IW-1:0] cfg_bin_hi = '0;
  logic [DW-1:0] cfg_threshold = '0;
  logic m_peak_valid;
  logic m_peak_ready = 1'b0;
  logic [NP*DW-1:0] m_peak_val;
  logic [NP*IW-1:0] m_peak_idx;
  logic [3:0] m_peak_count;
  logic m_frame_err;
  logic [DW-1:0] mag [1024];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fft_peak_picker #(.DATA_W(DW), .IDX_W(IW), .FRAME_LEN(1024), .NUM_PEAKS(NP)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_mag_tdata(s_mag_tdata), .s_mag_tvalid(s_mag_tvalid), .s_mag_tlast(s_mag_tlast),
    .s_mag_tready(s_mag_tready),
    .cfg_bin_lo(cfg_bin_lo), .cfg_bin_hi(cfg_bin_hi), .cfg_threshold(cfg_threshold),
    .m_peak_valid(m_peak_valid), .m_peak_ready(m_peak_ready),
    .m_peak_val(m_peak_val), .m_peak_idx(m_peak_idx),
    .m_peak_count(m_peak_count), .m_frame_err(m_frame_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input int i, input int v, input int x);
    chk($sformatf("%s val%0d", tag, i), 64'(m_peak_val[i*DW +: DW]), 64'(v));
    chk($sformatf("%s idx%0d", tag, i), 64'(m_peak_idx[i*IW +: IW]), 64'(x));
  endtask

  task automatic result(input string tag, input int cnt, input int err,
                        input int v0, input int x0, input int v1, input int x1,
                        input int v2, input int x2, input int v3, input int x3);
    chk({tag, " count"}, 64'(m_peak_count), 64'(cnt));
    chk({tag, " err"}, 64'(m_frame_err), 64'(err));
    slot(tag, 0, v0, x0);
    slot(tag, 1, v1, x1);
    slot(tag, 2, v2, x2);
    slot(tag, 3, v3, x3);
  endtask

  task automatic zero();
    for (int i = 0; i < 1024; i++) mag[i] = '0;
  endtask

  task automatic cfg(input int lo, input int hi, input int thr);
    cfg_bin_lo = IW'(lo);
    cfg_bin_hi = IW'(hi);
    cfg_threshold = DW'(thr);
  endtask

  task automatic send(input int n, input int tl, input int poke);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_mag_tvalid = 1'b1;
      s_mag_tdata = mag[i];
      s_mag_tlast = (i == tl);
      if (i == poke) cfg_threshold = '1;
    end
    @(negedge clk);
    s_mag_tvalid = 1'b0;
    s_mag_tlast = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    chk({tag, " flush valid"}, 64'(m_peak_valid), 64'(0));
    chk({tag, " flush tready"}, 64'(s_mag_tready), 64'(0));
    @(negedge clk);
    chk({tag, " result valid"}, 64'(m_peak_valid), 64'(1));
  endtask

  task automatic take(input string tag);
    m_peak_ready = 1'b1;
    @(negedge clk);
    m_peak_ready = 1'b0;
    chk({tag, " post tready"}, 64'(s_mag_tready), 64'(1));
    chk({tag, " post valid"}, 64'(m_peak_valid), 64'(0));
    chk({tag, " post count"}, 64'(m_peak_count), 64'(0));
    chk({tag, " post val0"}, 64'(m_peak_val[DW-1:0]), 64'(0));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " tready"}, 64'(s_mag_tready), 64'(1));
    chk({tag, " valid"}, 64'(m_peak_valid), 64'(0));
    result(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1 chk_reset("reset");
    @(negedge clk);
    reset_n = 1'b1;

    zero();
    mag[100] = 500;
    mag[300] = 900;
    cfg(1, 511, 0);
    send(1024, 1023, 5);
    wait_res("two");
    result("two", 2, 0, 900, 300, 500, 100, 0, 0, 0, 0);
    take("two");

    for (int i = 0; i < 1024; i++) mag[i] = DW'(i);
    cfg(0, 1023, 0);
    send(1024, 1023, -1);
    wait_res("ramp");
    result("ramp", 1, 0, 1023, 1023, 0, 0, 0, 0, 0, 0);
    take("ramp");

    zero();
    mag[100] = 30;
    mag[200] = 60;
    mag[300] = 10;
    mag[400] = 50;
    mag[500] = 20;
    mag[600] = 40;
    send(1024, 1023, -1);
    wait_res("six");
    result("six", 4, 0, 60, 200, 50, 400, 40, 600, 30, 100);
    take("six");

    cfg(600, 100, 0);
    send(1024, 1023, -1);
    wait_res("lo>hi");
    result("lo>hi", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    take("lo>hi");

    zero();
    mag[20] = 70;
    mag[40] = 70;
    mag[60] = 10;
    mag[900] = 99;
    cfg(0, 800, 0);
    send(1024, 1023, -1);
    wait_res("tie");
    result("tie", 3, 0, 70, 20, 70, 40, 10, 60, 0, 0);
    take("tie");

    zero();
    mag[50] = 80;
    mag[51] = 80;
    cfg(0, 1023, 100);
    send(1024, 1023, -1);
    wait_res("plateau thr100");
    result("plateau thr100", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    take("plateau thr100");
    cfg(0, 1023, 80);
    send(1024, 1023, -1);
    wait_res("plateau thr80");
    result("plateau thr80", 1, 0, 80, 50, 0, 0, 0, 0, 0, 0);
    take("plateau thr80");

    zero();
    mag[10] = 5;
    mag[511] = 7;
    cfg(0, 1023, 0);
    send(512, 511, -1);
    wait_res("early tlast");
    result("early tlast", 2, 1, 7, 511, 5, 10, 0, 0, 0, 0);
    take("early tlast");

    zero();
    mag[1023] = 3;
    send(1024, -1, -1);
    wait_res("no tlast");
    result("no tlast", 1, 1, 3, 1023, 0, 0, 0, 0, 0, 0);
    take("no tlast");

    zero();
    mag[0] = 9;
    send(1, 0, -1);
    wait_res("one beat");
    result("one beat", 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    take("one beat");

    zero();
    mag[100] = 500;
    mag[300] = 900;
    cfg(1, 511, 0);
    send(1024, 1023, -1);
    wait_res("hold");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("hold valid", 64'(m_peak_valid), 64'(1));
      chk("hold tready", 64'(s_mag_tready), 64'(0));
      chk("hold val0", 64'(m_peak_val[DW-1:0]), 64'(900));
      chk("hold idx1", 64'(m_peak_idx[2*IW-1:IW]), 64'(100));
    end
    reset_n = 1'b0;
    #1 chk_reset("reset in result");
    @(negedge clk);
    reset_n = 1'b1;

    send(300, -1, -1);
    chk("midframe tready", 64'(s_mag_tready), 64'(1));
    reset_n = 1'b0;
    #1 chk_reset("reset midframe");
    @(negedge clk);
    reset_n = 1'b1;
    send(1024, 1023, -1);
    wait_res("after reset");
    result("after reset", 2, 0, 900, 300, 500, 100, 0, 0, 0, 0);
    take("after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
